// File: rtl/mario_inputs.sv
// mario_inputs: PS/2 and joystick conditioning ahead of mario_top.
// Define MARIO_INPUT_KBD_EN to build in the PS/2 key decoder.
module mario_inputs #(
  parameter logic [23:0] COIN_PULSE = 24'd4_800_000,
  parameter logic [23:0] COIN_GAP   = 24'd4_800_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  output logic [7:0]  sw1,
  output logic [7:0]  sw2,
  output logic        coin_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } coin_st_t;

  localparam int K_L1 = 0;
  localparam int K_R1 = 1;
  localparam int K_F1 = 2;
  localparam int K_S1 = 3;
  localparam int K_S2 = 4;
  localparam int K_CN = 5;
  localparam int K_L2 = 6;
  localparam int K_R2 = 7;
  localparam int K_F2 = 8;
  localparam int K_TS = 9;

  logic [9:0] w_key;
  logic       w_unused;

`ifdef MARIO_INPUT_KBD_EN
  logic       r_old_tgl;
  logic [9:0] r_key;

  // Latch the pressed flag of each mapped key on a PS/2 event.
  always_ff @(posedge clk_sys) begin
    r_old_tgl <= ps2_key[10];
    if (reset) begin
      r_key <= '0;
    end else if (ps2_key[10] != r_old_tgl) begin
      case (ps2_key[8:0])
        9'h06B, 9'h16B: r_key[K_L1] <= ps2_key[9];
        9'h074, 9'h174: r_key[K_R1] <= ps2_key[9];
        9'h029, 9'h014: r_key[K_F1] <= ps2_key[9];
        9'h005, 9'h016: r_key[K_S1] <= ps2_key[9];
        9'h006, 9'h01E: r_key[K_S2] <= ps2_key[9];
        9'h02E, 9'h036: r_key[K_CN] <= ps2_key[9];
        9'h023:         r_key[K_L2] <= ps2_key[9];
        9'h034:         r_key[K_R2] <= ps2_key[9];
        9'h01C:         r_key[K_F2] <= ps2_key[9];
        9'h02C:         r_key[K_TS] <= ps2_key[9];
        default: ;
      endcase
    end
  end

  assign w_key    = r_key;
  assign w_unused = ^{joy_0[15:8], joy_0[3:2],
                      joy_1[15:8], joy_1[3:2]};
`else
  assign w_key    = '0;
  assign w_unused = ^{ps2_key,
                      joy_0[15:8], joy_0[3:2],
                      joy_1[15:8], joy_1[3:2]};
`endif

  logic [1:0]  r_raw1, r_raw2;
  logic        r_f1, r_f2, r_s1, r_s2, r_cn, r_ts;
  logic [1:0]  r_raw1_d, r_raw2_d;
  logic [1:0]  r_last1, r_last2;
  logic [1:0]  r_dir1, r_dir2;
  logic        r_f1_d, r_f2_d, r_s1_d, r_s2_d, r_ts_d, r_cn_d;
  coin_st_t    r_st, w_st_nx;
  logic [23:0] r_cnt, w_cnt_nx;
  logic [1:0]  r_pend, w_pend_nx;
  logic        w_dec, w_req;
  logic [1:0]  w_last1, w_last2, w_dir1, w_dir2;

  function automatic logic [1:0] last_nx(
    input logic [1:0] raw,
    input logic [1:0] raw_d,
    input logic [1:0] last
  );
    logic [1:0] np;
    np = raw & ~raw_d;
    if (np[1]) return 2'b10;
    if (np[0]) return 2'b01;
    return last;
  endfunction

  assign w_last1 = last_nx(r_raw1, r_raw1_d, r_last1);
  assign w_last2 = last_nx(r_raw2, r_raw2_d, r_last2);
  assign w_dir1  = (r_raw1 == 2'b11) ? w_last1 : r_raw1;
  assign w_dir2  = (r_raw2 == 2'b11) ? w_last2 : r_raw2;
  assign w_req   = r_cn & ~r_cn_d;

  // Stage 1: merge keyboard and pad bits into raw vectors.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_raw1 <= '0;
      r_raw2 <= '0;
      r_f1   <= 1'b0;
      r_f2   <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_cn   <= 1'b0;
      r_ts   <= 1'b0;
    end else begin
      r_raw1 <= {joy_0[1] | w_key[K_L1], joy_0[0] | w_key[K_R1]};
      r_raw2 <= {joy_1[1] | w_key[K_L2], joy_1[0] | w_key[K_R2]};
      r_f1   <= joy_0[4] | w_key[K_F1];
      r_f2   <= joy_1[4] | w_key[K_F2];
      r_s1   <= joy_0[5] | joy_1[5] | w_key[K_S1];
      r_s2   <= joy_0[6] | joy_1[6] | w_key[K_S2];
      r_cn   <= joy_0[7] | joy_1[7] | w_key[K_CN];
      r_ts   <= w_key[K_TS];
    end
  end

  // Stage 2: last-pressed direction resolve; buttons delayed to match.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_raw1_d <= '0;
      r_raw2_d <= '0;
      r_last1  <= '0;
      r_last2  <= '0;
      r_dir1   <= '0;
      r_dir2   <= '0;
      r_f1_d   <= 1'b0;
      r_f2_d   <= 1'b0;
      r_s1_d   <= 1'b0;
      r_s2_d   <= 1'b0;
      r_ts_d   <= 1'b0;
      r_cn_d   <= 1'b0;
    end else begin
      r_raw1_d <= r_raw1;
      r_raw2_d <= r_raw2;
      r_last1  <= w_last1;
      r_last2  <= w_last2;
      r_dir1   <= w_dir1;
      r_dir2   <= w_dir2;
      r_f1_d   <= r_f1;
      r_f2_d   <= r_f2;
      r_s1_d   <= r_s1;
      r_s2_d   <= r_s2;
      r_ts_d   <= r_ts;
      r_cn_d   <= r_cn;
    end
  end

  // Coin FSM state, counter and pending-credit registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_st   <= S_IDLE;
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      r_st   <= w_st_nx;
      r_cnt  <= w_cnt_nx;
      r_pend <= w_pend_nx;
    end
  end

  // Coin FSM next state, countdown and credit bookkeeping.
  always_comb begin
    w_st_nx   = r_st;
    w_cnt_nx  = r_cnt;
    w_dec     = 1'b0;
    w_pend_nx = r_pend;
    unique case (r_st)
      S_IDLE: begin
        if (r_pend != 2'd0) begin
          w_dec    = 1'b1;
          w_cnt_nx = COIN_PULSE - 24'd1;
          w_st_nx  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == 24'd0) begin
          w_cnt_nx = COIN_GAP - 24'd1;
          w_st_nx  = S_GAP;
        end else begin
          w_cnt_nx = r_cnt - 24'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == 24'd0) begin
          w_st_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 24'd1;
        end
      end
      default: w_st_nx = S_IDLE;
    endcase
    if (w_req && !w_dec && r_pend != 2'd3) begin
      w_pend_nx = r_pend + 2'd1;
    end else if (!w_req && w_dec) begin
      w_pend_nx = r_pend - 2'd1;
    end
  end

  // Stage 3: active-low switch bytes; coin comes only from the FSM.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sw1 <= 8'hFF;
      sw2 <= 8'hFF;
    end else begin
      sw1 <= {~r_ts_d, ~r_s2_d, ~r_s1_d, ~r_f1_d,
              2'b11, ~r_dir1[1], ~r_dir1[0]};
      sw2 <= {2'b11, ~(r_st == S_PULSE), ~r_f2_d,
              2'b11, ~r_dir2[1], ~r_dir2[0]};
    end
  end

  assign coin_busy = (r_st != S_IDLE) || (r_pend != 2'd0);

endmodule

// File: tb/tb_mario_inputs.sv
// tb_mario_inputs: scoreboard bench for mario_inputs.
// Uses COIN_PULSE=4, COIN_GAP=3; works with or without MARIO_INPUT_KBD_EN.
module tb_mario_inputs;

  localparam int PI = 4;
  localparam int GI = 3;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy_0 = '0;
  logic [15:0] joy_1 = '0;
  logic [7:0]  sw1, sw2;
  logic        coin_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  mario_inputs #(
    .COIN_PULSE(24'd4),
    .COIN_GAP  (24'd3)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .joy_0    (joy_0),
    .joy_1    (joy_1),
    .sw1      (sw1),
    .sw2      (sw2),
    .coin_busy(coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         due;
    logic [7:0] e1;
    logic [7:0] m1;
    logic [7:0] e2;
    logic [7:0] m2;
  } exp_t;

  exp_t       sbq[$];
  logic       sb_on = 1'b0;
  logic [9:0] kb_cur = '0;
  logic [9:0] kb_next = '0;
  logic [1:0] m_prev1 = '0;
  logic [1:0] m_prev2 = '0;
  logic [1:0] m_last1 = '0;
  logic [1:0] m_last2 = '0;
  logic       tg = 1'b0;

  task automatic model_reset();
    sbq.delete();
    kb_cur  = '0;
    kb_next = '0;
    m_prev1 = '0;
    m_prev2 = '0;
    m_last1 = '0;
    m_last2 = '0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_sys);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      total++;
      if (((sw1 & e.m1) !== (e.e1 & e.m1)) ||
          ((sw2 & e.m2) !== (e.e2 & e.m2))) begin
        bad++;
        $display("FAIL sb cyc=%0d got sw1=%h sw2=%h want sw1=%h/m%h sw2=%h/m%h",
                 cyc, sw1, sw2, e.e1, e.m1, e.e2, e.m2);
      end
    end
  endtask

  // Reference: 3-cycle path from the raw inputs seen this cycle.
  task automatic push_exp();
    exp_t e;
    logic [1:0] r1, r2, n1, n2, d1, d2;
    r1 = {joy_0[1] | kb_cur[0], joy_0[0] | kb_cur[1]};
    r2 = {joy_1[1] | kb_cur[6], joy_1[0] | kb_cur[7]};
    n1 = r1 & ~m_prev1;
    n2 = r2 & ~m_prev2;
    if (n1[1]) m_last1 = 2'b10;
    else if (n1[0]) m_last1 = 2'b01;
    if (n2[1]) m_last2 = 2'b10;
    else if (n2[0]) m_last2 = 2'b01;
    d1 = (r1 == 2'b11) ? m_last1 : r1;
    d2 = (r2 == 2'b11) ? m_last2 : r2;
    m_prev1 = r1;
    m_prev2 = r2;
    if (sb_on) begin
      e.due = cyc + 3;
      e.e1 = {~kb_cur[9], ~(joy_0[6] | joy_1[6] | kb_cur[4]),
              ~(joy_0[5] | joy_1[5] | kb_cur[3]),
              ~(joy_0[4] | kb_cur[2]), 2'b11, ~d1};
      e.m1 = 8'hFF;
      e.e2 = {3'b111, ~(joy_1[4] | kb_cur[8]), 2'b11, ~d2};
      e.m2 = 8'hFF;
      sbq.push_back(e);
    end
    kb_cur = kb_next;
  endtask

  task automatic cycle();
    push_exp();
    tick();
  endtask

  task automatic ps2_event(input logic [8:0] code, input logic pr);
    tg = ~tg;
    ps2_key = {tg, pr, code};
`ifdef MARIO_INPUT_KBD_EN
    case (code)
      9'h06B, 9'h16B: kb_next[0] = pr;
      9'h074, 9'h174: kb_next[1] = pr;
      9'h029, 9'h014: kb_next[2] = pr;
      9'h005, 9'h016: kb_next[3] = pr;
      9'h006, 9'h01E: kb_next[4] = pr;
      9'h02E, 9'h036: kb_next[5] = pr;
      9'h023:         kb_next[6] = pr;
      9'h034:         kb_next[7] = pr;
      9'h01C:         kb_next[8] = pr;
      9'h02C:         kb_next[9] = pr;
      default: ;
    endcase
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tg = 1'b1;
    ps2_key = {1'b1, 1'b1, 9'h16B};
    joy_0 = '0;
    joy_1 = '0;
    sb_on = 1'b0;
    model_reset();
    repeat (3) begin
      cycle();
      total++;
      if (sw1 !== 8'hFF) begin
        bad++;
        $display("FAIL rst_sw1 got=%h want=ff", sw1);
      end
      total++;
      if (sw2 !== 8'hFF) begin
        bad++;
        $display("FAIL rst_sw2 got=%h want=ff", sw2);
      end
      total++;
      if (coin_busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_busy got=%b want=0", coin_busy);
      end
    end
    reset = 1'b0;
    sb_on = 1'b1;
    repeat (8) cycle();
    total++;
    if (coin_busy !== 1'b0) begin
      bad++;
      $display("FAIL rel_busy got=%b want=0", coin_busy);
    end
  endtask

  task automatic test_joy_dir();
    logic [15:0] j0t [12];
    logic [15:0] j1t [12];
    int          ht  [12];
    j0t = '{16'h0002, 16'h0003, 16'h0002, 16'h0003, 16'h0001, 16'h0003,
            16'h0000, 16'h0003, 16'h0000, 16'h0030, 16'h0000, 16'h0000};
    j1t = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0003, 16'h0050, 16'h0002, 16'h0000};
    ht  = '{10, 10, 4, 4, 4, 4, 3, 4, 4, 4, 3, 6};
    for (int i = 0; i < 12; i++) begin
      joy_0 = j0t[i];
      joy_1 = j1t[i];
      repeat (ht[i]) cycle();
    end
  endtask

  task automatic test_ps2();
    logic [8:0] ct [11];
    logic       pt [11];
    ct = '{9'h16B, 9'h16B, 9'h014, 9'h02C, 9'h01A, 9'h014,
           9'h02C, 9'h034, 9'h074, 9'h034, 9'h074};
    pt = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_event(ct[i], pt[i]);
      repeat (6) cycle();
    end
  endtask

  task automatic test_coin_single();
    exp_t e;
    int   k;
    sb_on = 1'b0;
    repeat (4) cycle();
    k = cyc;
    joy_1[7] = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      e.due = k + t;
      e.e1 = 8'h00;
      e.m1 = 8'h00;
      e.e2 = (t >= 4 && t < 4 + PI) ? 8'h00 : 8'h20;
      e.m2 = 8'h20;
      sbq.push_back(e);
    end
    cycle();
    joy_1[7] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (cyc == k + 9) begin
        total++;
        if (coin_busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_gap got=%b want=1", coin_busy);
        end
      end
      if (cyc == k + 12) begin
        total++;
        if (coin_busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_idle got=%b want=0", coin_busy);
        end
      end
    end
  endtask

  task automatic test_coin_burst();
    int   k, run, hi, npulse, lastlow, fall, first_low, gap_bad, o, x;
    logic prev_busy, lvl;
    int   exp_len[$];
    int   obs_len[$];
    sb_on = 1'b0;
    repeat (4) cycle();
    k = cyc;
    run = 0;
    hi = 0;
    npulse = 0;
    lastlow = -1;
    fall = -1;
    first_low = -1;
    gap_bad = 0;
    prev_busy = 1'b0;
    repeat (4) exp_len.push_back(PI);
    for (int i = 0; i < 60; i++) begin
      joy_1[7] = (i < 10) && (i % 2 == 0);
      cycle();
      lvl = sw2[5];
      if (!lvl) begin
        if (run == 0) begin
          if (first_low < 0) first_low = cyc;
          if (npulse > 0 && hi < GI) gap_bad++;
          npulse++;
        end
        run++;
        hi = 0;
        lastlow = cyc;
      end else begin
        if (run > 0) obs_len.push_back(run);
        run = 0;
        hi++;
      end
      if (prev_busy && !coin_busy) fall = cyc;
      prev_busy = coin_busy;
    end
    total++;
    if (first_low != k + 4) begin
      bad++;
      $display("FAIL burst_first got=%0d want=%0d", first_low - k, 4);
    end
    total++;
    if (npulse != 4) begin
      bad++;
      $display("FAIL burst_count got=%0d want=4", npulse);
    end
    while (exp_len.size() > 0) begin
      x = exp_len.pop_front();
      o = (obs_len.size() > 0) ? obs_len.pop_front() : -1;
      total++;
      if (o != x) begin
        bad++;
        $display("FAIL burst_len got=%0d want=%0d", o, x);
      end
    end
    total++;
    if (gap_bad != 0) begin
      bad++;
      $display("FAIL burst_gap got=%0d short gaps want=0", gap_bad);
    end
    total++;
    if (fall < lastlow + GI || fall > lastlow + GI + 1) begin
      bad++;
      $display("FAIL burst_busy_fall got=%0d want=%0d", fall - lastlow, GI);
    end
    total++;
    if (coin_busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_busy_end got=%b want=0", coin_busy);
    end
  endtask

  task automatic test_reset_mid();
    int   nfall, busy_hi;
    logic prev;
    sb_on = 1'b0;
    repeat (4) cycle();
    nfall = 0;
    prev = 1'b1;
    for (int i = 0; i < 60 && nfall < 2; i++) begin
      joy_1[7] = (i < 8) && (i % 2 == 0);
      cycle();
      if (prev && !sw2[5]) nfall++;
      prev = sw2[5];
    end
    joy_1[7] = 1'b0;
    total++;
    if (nfall != 2) begin
      bad++;
      $display("FAIL mid_wait got=%0d pulses want=2", nfall);
    end
    reset = 1'b1;
    model_reset();
    cycle();
    total++;
    if (sw2 !== 8'hFF) begin
      bad++;
      $display("FAIL mid_sw2 got=%h want=ff", sw2);
    end
    total++;
    if (sw1 !== 8'hFF) begin
      bad++;
      $display("FAIL mid_sw1 got=%h want=ff", sw1);
    end
    total++;
    if (coin_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy got=%b want=0", coin_busy);
    end
    reset = 1'b0;
    sb_on = 1'b1;
    busy_hi = 0;
    repeat (30) begin
      cycle();
      if (coin_busy) busy_hi++;
    end
    total++;
    if (busy_hi != 0) begin
      bad++;
      $display("FAIL mid_after got=%0d busy cycles want=0", busy_hi);
    end
  endtask

  initial begin
    test_reset();
    test_joy_dir();
    test_ps2();
    test_coin_single();
    test_coin_burst();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
